intc_apb_if: RTL and testbench
==============================

# intc_apb_if

APB slave front-end of the interrupt controller register block. It terminates the APB3 protocol from the system bus, latches address, direction and write data in the setup phase, and inserts a configurable number of wait states. It drives the register-side address, write data and single-cycle write/read strobes. It returns the read-mux result as PRDATA with PSLVERR for illegal accesses. It sits directly upstream of the register file and the read-data mux, and consumes that mux's output.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- ADDR_BASE, 32'h0009_0000, address of register index 0
- NUM_REGS, 20, number of word registers mapped from ADDR_BASE (index i at ADDR_BASE+4*i)
- WAIT_CYCLES, 0, wait states per transfer (0..15)
- RO_MASK, NUM_REGS'b0, bit i set = register i read-only
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable (access phase)
- PWRITE  in  1  1 = write
- PADDR  in  ADDR_WIDTH  APB address
- PWDATA  in  DATA_WIDTH  APB write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error, valid only with PREADY
- reg_addr  out  ADDR_WIDTH  latched address to register file and read mux
- reg_wdata  out  DATA_WIDTH  latched write data
- wren  out  1  one-cycle write strobe
- rden  out  1  one-cycle read strobe (read side effects)
- rdata_in  in  DATA_WIDTH  read-mux output for reg_addr

## Operation
- States: IDLE, ACCESS.
- IDLE: on PSEL=1, PENABLE=0, latch the following: PADDR→reg_addr, PWRITE→wr_q, PWDATA→reg_wdata. Also latch err_q. Clear the wait counter and go to ACCESS.
- err_q=1 in any of these cases: PADDR[1:0]≠0; PADDR<ADDR_BASE; PADDR>ADDR_BASE+4*(NUM_REGS-1); or a write to an index with RO_MASK set.
- IDLE with PSEL=1, PENABLE=1 (no setup phase): ignored, stay IDLE, PREADY=0.
- ACCESS, PSEL=1 and PENABLE=1: the counter increments each cycle until it reaches WAIT_CYCLES.
  - PREADY = (state==ACCESS)&&PSEL&&PENABLE&&(cnt==WAIT_CYCLES).
  - The PREADY cycle returns the state to IDLE.
- ACCESS with PSEL=0 or PENABLE=0 before PREADY: abort to IDLE. No strobe, PREADY stays 0.
- PREADY cycle outputs:
  - wren = wr_q&&!err_q; rden = !wr_q&&!err_q.
  - PSLVERR = err_q.
  - PRDATA = rdata_in if (!wr_q&&!err_q), else 0.
- Outside the PREADY cycle: PRDATA=0, PSLVERR=0, wren=0, rden=0.
- Errored access: no strobe, PRDATA=0, register state untouched.
- Back-to-back transfers: the cycle after PREADY is IDLE and may itself be the next setup phase, so there are no dead cycles.
- Reset (PRESETn=0 at an edge) wins over everything:
  - State→IDLE, counter=0.
  - reg_addr=0, reg_wdata=0, wr_q=0, err_q=0.
  - An in-flight transfer is dropped with no wren.

## Timing
- Zero-wait transfer takes 2 cycles: setup T0, PREADY in T1.
- N wait states: PREADY in T(1+N).
- Output reset values: PRDATA=0, PREADY=0, PSLVERR=0, wren=0, rden=0, reg_addr=0, reg_wdata=0.
- reg_addr and reg_wdata are registered. They are stable from T1 until the next setup capture.
- PRDATA, PREADY, PSLVERR, wren and rden are combinational from state, counter and latched flags.
- rdata_in is combinational from reg_addr; it is sampled by the master in the PREADY cycle.
- The register file commits its write on the edge ending the wren cycle.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1. It never wraps.

## Structure
- Shared package intc_pkg holds the following:
  - INTC_ADDR_BASE, INTC_NUM_REGS.
  - Per-register offset constants (INTCR 0x00 … IPRN 0x4C).
  - typedef enum logic {IDLE, ACCESS} apb_state_t.
- One natural sub-module: intc_apb_decode. It is combinational and computes the in-range, aligned and read-only error flag and the index from PADDR and PWRITE. It is reused by verification models.

## Test plan
- Zero-wait write, 0x0009_000C / 0xA5A5_0001 → PREADY in T1, wren=1 for exactly one cycle, reg_addr=0x0009_000C, reg_wdata=0xA5A5_0001, PSLVERR=0.
- WAIT_CYCLES=2, read 0x0009_0010, rdata_in=0x0000_00F0 → PREADY low T1–T2, high T3 with PRDATA=0x0000_00F0, rden pulse in T3, PRDATA=0 in T4.
- Read 0x0009_0050, then write 0x0009_0006, then write an RO_MASK index → each gives PREADY with PSLVERR=1, PRDATA=0, no wren or rden.
- Write 0x0009_0018 immediately followed by read 0x0009_0018 with no idle cycle → second setup captured in the first transfer's following cycle, wren then rden, total 4 cycles.
- PRESETn=0 during a wait state, and separately PSEL dropped mid-ACCESS → next cycle IDLE, all outputs 0, no wren. The following normal transfer completes correctly.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared constants and types for the interrupt controller register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package intc_pkg;

    localparam logic [31:0] INTC_ADDR_BASE = 32'h0009_0000;
    localparam int          INTC_NUM_REGS  = 20;

    // Byte offsets of the word registers relative to INTC_ADDR_BASE
    localparam logic [7:0] INTCR_OFS = 8'h00;
    localparam logic [7:0] INTSR_OFS = 8'h04;
    localparam logic [7:0] IENR_OFS  = 8'h08;
    localparam logic [7:0] IDISR_OFS = 8'h0C;
    localparam logic [7:0] IPNDR_OFS = 8'h10;
    localparam logic [7:0] ICLRR_OFS = 8'h14;
    localparam logic [7:0] IMSKR_OFS = 8'h18;
    localparam logic [7:0] IVECR_OFS = 8'h1C;
    localparam logic [7:0] ITRGR_OFS = 8'h20;
    localparam logic [7:0] IPOLR_OFS = 8'h24;
    localparam logic [7:0] IPR0_OFS  = 8'h28;
    localparam logic [7:0] IPR1_OFS  = 8'h2C;
    localparam logic [7:0] IPR2_OFS  = 8'h30;
    localparam logic [7:0] IPR3_OFS  = 8'h34;
    localparam logic [7:0] IPR4_OFS  = 8'h38;
    localparam logic [7:0] IPR5_OFS  = 8'h3C;
    localparam logic [7:0] IPR6_OFS  = 8'h40;
    localparam logic [7:0] IPR7_OFS  = 8'h44;
    localparam logic [7:0] IPR8_OFS  = 8'h48;
    localparam logic [7:0] IPRN_OFS  = 8'h4C;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

endpackage

// File: rtl/intc_apb_decode.sv
// Address decode: register index plus the illegal-access flag (misaligned, out of range, RO write).
// Latency: purely combinational.
// Backpressure: none; evaluates whatever address is presented.
module intc_apb_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 32'h0009_0000,
    parameter int                    NUM_REGS   = 20,
    parameter int                    IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    output logic                  err,
    output logic [IDX_WIDTH-1:0]  idx
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_REGS - 1);

    logic [ADDR_WIDTH-1:0] ofs;
    logic [ADDR_WIDTH-1:0] word;
    logic                  aligned;
    logic                  in_range;
    logic                  ro;

    // Word offset from the base, range/alignment tests and the read-only lookup
    always_comb begin
        ofs      = paddr - ADDR_BASE;
        word     = ofs >> 2;
        aligned  = (paddr[1:0] == 2'b00);
        in_range = (paddr >= ADDR_BASE) && (word <= LAST_WORD);
        idx      = word[IDX_WIDTH-1:0];
        ro       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && (word == ADDR_WIDTH'(i))) begin
                ro = RO_MASK[i];
            end
        end
        err = !aligned || !in_range || (pwrite && ro);
    end

endmodule

// File: rtl/intc_apb_if.sv
// APB3 slave front-end: latches the setup phase, inserts WAIT_CYCLES wait states, strobes the register file.
// Latency: setup cycle plus 1+WAIT_CYCLES access cycles; PREADY/PRDATA/strobes are combinational.
// Backpressure: PREADY held low during wait states; dropping PSEL/PENABLE mid-access aborts without a strobe.
module intc_apb_if
    import intc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = ADDR_WIDTH'(INTC_ADDR_BASE),
    parameter int                    NUM_REGS    = INTC_NUM_REGS,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  wren,
    output logic                  rden,
    input  logic [DATA_WIDTH-1:0] rdata_in
);

    localparam int               CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);
    localparam int               IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_t       state_q;
    apb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_q;
    logic             err_q;
    logic             setup;
    logic             dec_err;
    // The index is consumed by verification models; this block only needs the error flag
    logic [IDX_W-1:0] dec_idx_unused;

    intc_apb_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_BASE  (ADDR_BASE),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .paddr  (PADDR),
        .pwrite (PWRITE),
        .err    (dec_err),
        .idx    (dec_idx_unused)
    );

    // State, wait counter and the setup-phase capture of address, data, direction and error
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                reg_addr  <= PADDR;
                reg_wdata <= PWDATA;
                wr_q      <= PWRITE;
                err_q     <= dec_err;
            end
        end
    end

    // Next state, counter advance and PREADY; an access phase without a setup phase is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = 1'b0;
        PREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup   = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    PREADY  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Completion-cycle outputs; errored accesses return zero data and never strobe
    always_comb begin
        wren    = PREADY && wr_q && !err_q;
        rden    = PREADY && !wr_q && !err_q;
        PSLVERR = PREADY && err_q;
        PRDATA  = rden ? rdata_in : '0;
    end

endmodule

// File: tb/tb_intc_apb_if.sv
// Bench for intc_apb_if: two instances (0 and 2 wait states) each backed by a small register-file model.
// Latency: n/a.
// Backpressure: n/a.
module tb_intc_apb_if;

    localparam logic [31:0] BASE  = 32'h0009_0000;
    localparam int          NREG  = 20;
    localparam logic [19:0] RO0   = 20'h00020;
    localparam logic [19:0] RO1   = 20'h80001;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic [1:0]        psel, penable, pwrite;
    logic [1:0][31:0]  paddr, pwdata, prdata, reg_addr, reg_wdata, rdata_in;
    logic [1:0]        pready, pslverr, wren, rden;

    int          nvec = 0;
    int          nmis = 0;
    int          cyc  = 0;
    logic        rf_load;
    logic [31:0] rf [2][32];
    logic [31:0] model [2][NREG];
    logic [19:0] ro_m [2];
    int          waits_m [2];

    typedef struct {
        int          w;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        bit          e_err;
        logic [31:0] e_rd;
    } vec_t;
    vec_t tbl [16];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    intc_apb_if #(.WAIT_CYCLES(0), .RO_MASK(RO0)) u0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .reg_addr(reg_addr[0]), .reg_wdata(reg_wdata[0]),
        .wren(wren[0]), .rden(rden[0]), .rdata_in(rdata_in[0]));

    intc_apb_if #(.WAIT_CYCLES(2), .RO_MASK(RO1)) u1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .reg_addr(reg_addr[1]), .reg_wdata(reg_wdata[1]),
        .wren(wren[1]), .rden(rden[1]), .rdata_in(rdata_in[1]));

    function automatic int word_idx(logic [31:0] a);
        if (a < BASE || a >= BASE + 32'(4 * NREG)) return -1;
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] pat(int w, int i);
        return 32'h1000_0000 | (32'(w) << 16) | 32'(i);
    endfunction

    // Reference error rule: misaligned, below base, past last register, or a write to a read-only one
    function automatic bit m_err(int w, logic [31:0] a, bit wr);
        if ((a % 4) != 0) return 1'b1;
        if (a < BASE) return 1'b1;
        if (a > BASE + 32'(4 * (NREG - 1))) return 1'b1;
        if (wr && ro_m[w][(a - BASE) / 4]) return 1'b1;
        return 1'b0;
    endfunction

    // Register file read mux: combinational from reg_addr
    always_comb begin
        rdata_in = '0;
        for (int w = 0; w < 2; w++) begin
            if (word_idx(reg_addr[w]) >= 0) rdata_in[w] = rf[w][word_idx(reg_addr[w]) & 31];
            else                            rdata_in[w] = 32'hDEAD_BEEF;
        end
    end

    // Register file commits on the edge that ends a wren cycle
    always @(posedge PCLK) begin
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) begin
                if (rf_load) rf[w][i] <= pat(w, i);
                else if (wren[w] && word_idx(reg_addr[w]) == i) rf[w][i] <= reg_wdata[w];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle(input int w);
        @(posedge PCLK); #1;
        psel[w] = 1'b0; penable[w] = 1'b0;
    endtask

    task automatic xfer(input int w, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input bit e_err, input logic [31:0] e_rd, output int s_cyc, output int r_cyc);
        int  nw, nwr, nrd;
        bit  got;
        @(posedge PCLK); #1;
        psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = wd;
        s_cyc = cyc;
        @(negedge PCLK);
        chk("setup_quiet", {pready[w], wren[w], rden[w], pslverr[w], |prdata[w]}, 0);
        @(posedge PCLK); #1;
        penable[w] = 1'b1;
        nw = 0; nwr = 0; nrd = 0; got = 1'b0; r_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge PCLK);
            nwr += int'(wren[w]);
            nrd += int'(rden[w]);
            if (pready[w]) begin
                got = 1'b1;
                r_cyc = cyc;
                break;
            end
            chk("wait_quiet", {wren[w], rden[w], pslverr[w], |prdata[w]}, 0);
            nw++;
            @(posedge PCLK); #1;
        end
        chk("pready_seen", got, 1);
        if (got) begin
            chk("wait_states", nw, waits_m[w]);
            chk("pslverr", pslverr[w], e_err);
            chk("prdata", prdata[w], e_rd);
            chk("reg_addr", reg_addr[w], a);
            chk("wren_pulses", nwr, (wr && !e_err) ? 1 : 0);
            chk("rden_pulses", nrd, (!wr && !e_err) ? 1 : 0);
            if (wr) chk("reg_wdata", reg_wdata[w], wd);
        end
        if (wr && !e_err) model[w][(a - BASE) / 4] = wd;
    endtask

    initial begin
        int s1, r1, s2, r2;
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, r1, s2, r2, w, kind, k;
        logic [31:0] a, wd, erd;
        bit wr, e;

        ro_m[0] = RO0; ro_m[1] = RO1;
        waits_m[0] = 0; waits_m[1] = 2;
        for (int ww = 0; ww < 2; ww++)
            for (int i = 0; i < NREG; i++) model[ww][i] = pat(ww, i);

        tbl[0]  = '{0, 32'h0009_000C, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0};
        tbl[1]  = '{0, 32'h0009_000C, 1'b0, 32'h0,         1'b0, 32'hA5A5_0001};
        tbl[2]  = '{1, 32'h0009_0010, 1'b1, 32'h0000_00F0, 1'b0, 32'h0};
        tbl[3]  = '{1, 32'h0009_0010, 1'b0, 32'h0,         1'b0, 32'h0000_00F0};
        tbl[4]  = '{0, 32'h0009_0050, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{0, 32'h0009_0006, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[6]  = '{0, 32'h0009_0014, 1'b1, 32'h1234_0000, 1'b1, 32'h0};
        tbl[7]  = '{0, 32'h0009_0014, 1'b0, 32'h0,         1'b0, 32'h1000_0005};
        tbl[8]  = '{1, 32'h0009_0000, 1'b1, 32'h5555_5555, 1'b1, 32'h0};
        tbl[9]  = '{1, 32'h0009_0000, 1'b0, 32'h0,         1'b0, 32'h1001_0000};
        tbl[10] = '{0, 32'h0008_FFFC, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{0, 32'h0009_004C, 1'b0, 32'h0,         1'b0, 32'h1000_0013};
        tbl[12] = '{0, 32'h0009_004C, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[13] = '{0, 32'h0009_004C, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[14] = '{1, 32'h0009_004C, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0};
        tbl[15] = '{1, 32'h0009_004C, 1'b0, 32'h0,         1'b0, 32'h1001_0013};

        PRESETn = 1'b0; rf_load = 1'b1;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        for (int ww = 0; ww < 2; ww++)
            chk("reset_outs", {pready[ww], wren[ww], rden[ww], pslverr[ww], prdata[ww],
                               reg_addr[ww], reg_wdata[ww]}, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1; rf_load = 1'b0;

        // Directed table, applied back to back per instance
        for (int i = 0; i < 16; i++) begin
            xfer(tbl[i].w, tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].e_err, tbl[i].e_rd, s1, r1);
            if (i == 15 || tbl[i + 1].w != tbl[i].w) idle(tbl[i].w);
        end
        idle(0); idle(1);

        // Write then read of the same register with no idle cycle between them
        xfer(0, 32'h0009_0018, 1'b1, 32'h1234_5678, 1'b0, 32'h0, s1, r1);
        xfer(0, 32'h0009_0018, 1'b0, 32'h0, 1'b0, 32'h1234_5678, s2, r2);
        chk("b2b_total_cycles", r2 - s1, 3);
        chk("b2b_no_gap", s2 - r1, 1);
        idle(0);

        // Reset during a wait state drops the in-flight write
        @(posedge PCLK); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h0009_0020; pwdata[1] = 32'h0000_0055;
        @(posedge PCLK); #1; penable[1] = 1'b1;
        @(negedge PCLK);
        chk("rst_wait_pready", {pready[1], wren[1]}, 0);
        @(posedge PCLK); #1; PRESETn = 1'b0;
        @(negedge PCLK);
        chk("rst_wait_pre", {pready[1], wren[1]}, 0);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_wait_outs", {pready[1], wren[1], rden[1], pslverr[1], prdata[1],
                              reg_addr[1], reg_wdata[1]}, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
        xfer(1, 32'h0009_0020, 1'b0, 32'h0, 1'b0, model[1][8], s1, r1);
        idle(1);

        // PSEL dropped mid-access aborts without a strobe
        @(posedge PCLK); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h0009_0024; pwdata[1] = 32'h0000_0077;
        @(posedge PCLK); #1; penable[1] = 1'b1;
        @(negedge PCLK);
        chk("abort_wait", {pready[1], wren[1]}, 0);
        @(posedge PCLK); #1; psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge PCLK);
        chk("abort_outs", {pready[1], wren[1], rden[1], pslverr[1], prdata[1]}, 0);
        repeat (3) begin
            @(negedge PCLK);
            chk("abort_no_strobe", {pready[1], wren[1]}, 0);
        end
        xfer(1, 32'h0009_0024, 1'b0, 32'h0, 1'b0, model[1][9], s1, r1);
        idle(1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            w    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            k    = int'($urandom_range(0, NREG - 1));
            case (kind)
                0:       a = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
                1:       a = BASE - 32'(4 * $urandom_range(1, 16));
                2:       a = BASE + 32'(4 * $urandom_range(NREG, 40));
                default: a = BASE + 32'(4 * k);
            endcase
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            e   = m_err(w, a, wr);
            erd = (!wr && !e) ? model[w][(a - BASE) / 4] : 32'h0;
            xfer(w, a, wr, wd, e, erd, s1, r1);
            if ($urandom_range(0, 3) == 0 || n == 79) idle(w);
            else if (w == 0) idle(0);
            else idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
